// File: rtl/fifo_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_share_arbiter_if
// Description : Bundle of producer, consumer and FIFO-strobe signals shared
//               between the write arbiter and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 8
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      rd_req;
    logic                      rd_gnt;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      fifo_rd_en;
    logic [LW-1:0]             level;
    logic [OW-1:0]             owner;

    // Environment side: producers, consumer and FIFO.
    modport master (
        output req, req_data, rd_req,
        input  gnt, rd_gnt, fifo_wr_en, fifo_wr_data, fifo_rd_en, level, owner
    );

    // Arbiter side.
    modport slave (
        input  req, req_data, rd_req,
        output gnt, rd_gnt, fifo_wr_en, fifo_wr_data, fifo_rd_en, level, owner
    );
endinterface
`default_nettype wire

// File: rtl/fifo_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_share_arbiter
// Description : Round-robin write arbiter with bounded bursts and a read
//               sequencer for a shared FIFO. A shadow occupancy count gates
//               both directions so the FIFO can never over- or underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            ena,
    fifo_share_arbiter_if.slave  bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [LW-1:0] DEPTH_L     = LW'(DEPTH);
    localparam logic [BW-1:0] MAX_BURST_L = BW'(MAX_BURST);
    localparam logic [OW-1:0] LAST_REQ    = OW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [BW-1:0]       burst_cnt, burst_nx;
    logic [OW-1:0]       cur_owner, winner;
    logic [LW-1:0]       level_q;
    logic                wr_en_q, rd_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                space, wr_go, rd_go, hold_owner, found;
    logic [NUM_REQ-1:0]  gnt_w;
    int                  idx;

    // Pick the winner: keep the current owner while its burst lasts,
    // otherwise scan upward from owner+1 with the owner itself checked last.
    always_comb begin
        winner     = cur_owner;
        found      = 1'b0;
        idx        = 0;
        hold_owner = (state == HOLD) && bus.req[cur_owner] && (burst_cnt < MAX_BURST_L);
        if (!hold_owner) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(cur_owner) + k) % NUM_REQ;
                if (!found && bus.req[idx]) begin
                    winner = OW'(idx);
                    found  = 1'b1;
                end
            end
        end
    end

    // Grant qualification; a same-cycle read never frees room for a write.
    always_comb begin
        space = (level_q < DEPTH_L);
        wr_go = rst_n & ena & space & (|bus.req);
        rd_go = rst_n & ena & bus.rd_req & (level_q != '0);
        gnt_w = wr_go ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    end

    // Next-state and burst bookkeeping; a stall with the owner still
    // requesting keeps the burst intact.
    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        if (wr_go) begin
            state_nx = HOLD;
            if ((state == HOLD) && (winner == cur_owner)) begin
                // Saturate: any count at or above MAX_BURST behaves the same.
                burst_nx = (burst_cnt < MAX_BURST_L) ? burst_cnt + BW'(1) : burst_cnt;
            end else begin
                burst_nx = BW'(1);
            end
        end else if (!bus.req[cur_owner]) begin
            state_nx = IDLE;
            burst_nx = '0;
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    // Registered FIFO strobes, owner tracking and shadow occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            level_q   <= '0;
            cur_owner <= LAST_REQ;
        end else begin
            wr_en_q <= wr_go;
            rd_en_q <= rd_go;
            if (wr_go) begin
                wr_data_q <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
                cur_owner <= winner;
            end
            case ({wr_go, rd_go})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.gnt          = gnt_w;
    assign bus.rd_gnt       = rd_go;
    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.fifo_rd_en   = rd_en_q;
    assign bus.level        = level_q;
    assign bus.owner        = cur_owner;
endmodule
`default_nettype wire

// File: tb/tb_fifo_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_share_arbiter
// Description : Directed self-checking bench for fifo_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_share_arbiter;
    logic clk;
    logic rst_n;
    logic ena;
    int   tests;
    int   fails;

    fifo_share_arbiter_if #(.NUM_REQ(4), .DATA_W(4), .DEPTH(8)) bus ();

    fifo_share_arbiter #(.NUM_REQ(4), .DATA_W(4), .DEPTH(8), .MAX_BURST(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.req      = '0;
        bus.rd_req   = 1'b0;
        bus.req_data = 16'hDCBA;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.req      = 4'b1111;
        bus.rd_req   = 1'b1;
        bus.req_data = 16'hDCBA;
        tick();
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        tests++; if (bus.rd_gnt !== 1'b0) begin fails++; $display("FAIL reset_rd_gnt: got %b want 0", bus.rd_gnt); end
        tests++; if (bus.level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        tests++; if (bus.owner !== 2'd3) begin fails++; $display("FAIL reset_owner: got %0d want 3", bus.owner); end
        tests++; if ({bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_data} !== 6'd0) begin
            fails++; $display("FAIL reset_strobes: got %b/%b/%h want 0/0/0", bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_data); end

        // Build a burst on producer 2, then drop reset between edges.
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        tests++; if (bus.level !== 4'd2 || bus.fifo_wr_en !== 1'b1) begin
            fails++; $display("FAIL pre_async_level: got %0d/%b want 2/1", bus.level, bus.fifo_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 4'h0) begin
            fails++; $display("FAIL async_strobe: got %b/%h want 0/0", bus.fifo_wr_en, bus.fifo_wr_data); end
        tests++; if (bus.level !== 4'd0 || bus.owner !== 2'd3) begin
            fails++; $display("FAIL async_level_owner: got %0d/%0d want 0/3", bus.level, bus.owner); end
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL async_gnt: got %b want 0000", bus.gnt); end
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        #1;
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL post_reset_search: got %b want 0001", bus.gnt); end
        bus.req = '0;
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        bus.req      = 4'b0100;
        bus.req_data = 16'h0A00;
        #1;
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
        tick();
        bus.req = '0;
        tests++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 4'hA) begin
            fails++; $display("FAIL single_strobe: got %b/%h want 1/a", bus.fifo_wr_en, bus.fifo_wr_data); end
        tests++; if (bus.level !== 4'd1 || bus.owner !== 2'd2) begin
            fails++; $display("FAIL single_level_owner: got %0d/%0d want 1/2", bus.level, bus.owner); end
        tick();
        tests++; if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 4'hA) begin
            fails++; $display("FAIL single_after: got %b/%h want 0/a", bus.fifo_wr_en, bus.fifo_wr_data); end
    endtask

    task automatic test_burst_rr();
        logic [1:0] order [8];
        logic [3:0] data_of [4];
        logic [3:0] exp_gnt;
        order   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        data_of = '{4'hA, 4'hB, 4'hC, 4'hD};
        do_reset();
        bus.req_data = 16'hDCBA;
        bus.req      = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_gnt = 4'b0001 << order[k];
            tests++; if (bus.gnt !== exp_gnt) begin fails++; $display("FAIL burst_gnt[%0d]: got %b want %b", k, bus.gnt, exp_gnt); end
            tick();
            tests++; if (bus.fifo_wr_data !== data_of[order[k]] || bus.level !== 4'(k + 1)) begin
                fails++; $display("FAIL burst_data_level[%0d]: got %h/%0d want %h/%0d", k, bus.fifo_wr_data, bus.level, data_of[order[k]], k + 1); end
        end
        #1;
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL burst_full_gnt: got %b want 0000", bus.gnt); end
        tick();
        tests++; if (bus.fifo_wr_en !== 1'b0 || bus.level !== 4'd8) begin
            fails++; $display("FAIL burst_full_hold: got %b/%0d want 0/8", bus.fifo_wr_en, bus.level); end
    endtask

    // Continues from the full FIFO left by test_burst_rr.
    task automatic test_full_drain();
        bus.rd_req = 1'b1;
        #1;
        tests++; if (bus.rd_gnt !== 1'b1 || bus.gnt !== 4'b0000) begin
            fails++; $display("FAIL drain_grants: got %b/%b want 1/0000", bus.rd_gnt, bus.gnt); end
        tick();
        bus.rd_req = 1'b0;
        tests++; if (bus.level !== 4'd7 || bus.fifo_rd_en !== 1'b1) begin
            fails++; $display("FAIL drain_level: got %0d/%b want 7/1", bus.level, bus.fifo_rd_en); end
        #1;
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL refill_gnt: got %b want 0001", bus.gnt); end
        tick();
        bus.req = '0;
        tests++; if (bus.level !== 4'd8 || bus.fifo_wr_en !== 1'b1 || bus.owner !== 2'd0 || bus.fifo_rd_en !== 1'b0) begin
            fails++; $display("FAIL refill_state: got %0d/%b/%0d/%b want 8/1/0/0", bus.level, bus.fifo_wr_en, bus.owner, bus.fifo_rd_en); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.req = 4'b0001;
        tick();
        tick();
        tick();
        tests++; if (bus.level !== 4'd3) begin fails++; $display("FAIL sim_setup_level: got %0d want 3", bus.level); end
        bus.req    = 4'b0010;
        bus.rd_req = 1'b1;
        #1;
        tests++; if (bus.gnt !== 4'b0010 || bus.rd_gnt !== 1'b1) begin
            fails++; $display("FAIL sim_grants: got %b/%b want 0010/1", bus.gnt, bus.rd_gnt); end
        tick();
        bus.req    = '0;
        bus.rd_req = 1'b0;
        tests++; if (bus.level !== 4'd3 || bus.fifo_wr_en !== 1'b1 || bus.fifo_rd_en !== 1'b1 || bus.owner !== 2'd1) begin
            fails++; $display("FAIL sim_result: got %0d/%b/%b/%0d want 3/1/1/1", bus.level, bus.fifo_wr_en, bus.fifo_rd_en, bus.owner); end
    endtask

    task automatic test_empty_ena();
        do_reset();
        bus.rd_req = 1'b1;
        #1;
        tests++; if (bus.rd_gnt !== 1'b0) begin fails++; $display("FAIL empty_rd_gnt: got %b want 0", bus.rd_gnt); end
        tick();
        bus.rd_req = 1'b0;
        tests++; if (bus.fifo_rd_en !== 1'b0 || bus.level !== 4'd0) begin
            fails++; $display("FAIL empty_no_read: got %b/%0d want 0/0", bus.fifo_rd_en, bus.level); end
        ena     = 1'b0;
        bus.req = 4'b0001;
        #1;
        tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL ena_low_gnt: got %b want 0000", bus.gnt); end
        tick();
        tests++; if (bus.fifo_wr_en !== 1'b0 || bus.level !== 4'd0) begin
            fails++; $display("FAIL ena_low_hold: got %b/%0d want 0/0", bus.fifo_wr_en, bus.level); end
        ena = 1'b1;
        #1;
        tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL ena_high_gnt: got %b want 0001", bus.gnt); end
        tick();
        bus.req = '0;
        tests++; if (bus.level !== 4'd1 || bus.fifo_wr_en !== 1'b1) begin
            fails++; $display("FAIL ena_high_write: got %0d/%b want 1/1", bus.level, bus.fifo_wr_en); end
        ena        = 1'b0;
        bus.rd_req = 1'b1;
        #1;
        tests++; if (bus.rd_gnt !== 1'b0) begin fails++; $display("FAIL ena_low_rd_gnt: got %b want 0", bus.rd_gnt); end
        tick();
        tests++; if (bus.level !== 4'd1 || bus.fifo_rd_en !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
            fails++; $display("FAIL ena_low_level: got %0d/%b/%b want 1/0/0", bus.level, bus.fifo_rd_en, bus.fifo_wr_en); end
        bus.rd_req = 1'b0;
        ena        = 1'b1;
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.req      = '0;
        bus.rd_req   = 1'b0;
        bus.req_data = '0;
        test_reset();
        test_single_write();
        test_burst_rr();
        test_full_drain();
        test_simultaneous();
        test_empty_ena();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
